// File: rtl/dm_wait_responder_pkg.sv
// Shared types and constants for the data-memory wait responder and its
// latency counter.
package dm_wait_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_e;

    localparam int LAT_MIN   = 1;
    localparam int LAT_MAX   = 15;
    localparam int LAT_CNT_W = 4;

    localparam logic [15:0] CNT_SAT = 16'hFFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_SAT) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dm_latency_counter.sv
// Loadable down-counter with a zero flag; stops at zero rather than wrapping.
module dm_latency_counter
    import dm_wait_responder_pkg::*;
#(
    parameter int WIDTH = LAT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i)
            count_d = load_val_i;
        else if (dec_i && (count_q != '0))
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/dm_wait_responder.sv
// Memory end of the CPU data-memory port: one request at a time, fixed
// multi-cycle latency, stall while busy, sticky out-of-range flag.
module dm_wait_responder
    import dm_wait_responder_pkg::*;
#(
    parameter int bit_size = 32,
    parameter int mem_size = 16,
    parameter int DEPTH    = 128,
    parameter int LATENCY  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                DM_req,
    input  logic                DM_enable,
    input  logic [mem_size-1:0] DM_Address,
    input  logic [bit_size-1:0] DM_Write_Data,
    output logic [bit_size-1:0] DM_Read_Data,
    output logic                DM_ready,
    output logic                DM_stall,
    output logic                DM_err,
    output logic [15:0]         rd_count,
    output logic [15:0]         wr_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [mem_size:0]      DEPTH_W  = (mem_size+1)'(DEPTH);
    localparam logic [LAT_CNT_W-1:0]   LAT_LOAD = LAT_CNT_W'(LATENCY - 1);

    logic [bit_size-1:0] DM_data [DEPTH];

    dm_state_e           state_q, state_d;
    logic [mem_size-1:0] addr_q, addr_d;
    logic                we_q, we_d;
    logic [bit_size-1:0] wdata_q, wdata_d;
    logic [bit_size-1:0] rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [15:0]         rd_cnt_q, rd_cnt_d;
    logic [15:0]         wr_cnt_q, wr_cnt_d;

    logic          cnt_load, cnt_dec, cnt_zero;
    logic          in_range, complete;
    logic [AW-1:0] mem_idx;

    dm_latency_counter #(.WIDTH(LAT_CNT_W)) u_lat (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (LAT_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Range test is done one bit wider so DEPTH == 2**mem_size still works.
    assign in_range = ({1'b0, addr_q} < DEPTH_W);
    assign mem_idx  = addr_q[AW-1:0];
    assign complete = (state_q == ST_WAIT) && cnt_zero;
    assign cnt_load = (state_q == ST_IDLE) && DM_req;
    assign cnt_dec  = (state_q == ST_WAIT);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (DM_req) begin
                    addr_d  = DM_Address;
                    we_d    = DM_enable;
                    wdata_d = DM_Write_Data;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_zero) begin
                    state_d = ST_RESP;
                    if (!in_range)
                        err_d = 1'b1;
                    if (we_q) begin
                        wr_cnt_d = sat_inc(wr_cnt_q);
                    end else begin
                        rd_cnt_d = sat_inc(rd_cnt_q);
                        rdata_d  = in_range ? DM_data[mem_idx] : '0;
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Storage survives reset; a reset during WAIT forces IDLE, so no write lands.
    always_ff @(posedge clk) begin
        if (complete && we_q && in_range)
            DM_data[mem_idx] <= wdata_q;
    end

    assign DM_Read_Data = rdata_q;
    assign DM_ready     = (state_q == ST_RESP);
    assign DM_stall     = ((state_q == ST_IDLE) && DM_req) || (state_q == ST_WAIT);
    assign DM_err       = err_q;
    assign rd_count     = rd_cnt_q;
    assign wr_count     = wr_cnt_q;

endmodule

// File: tb/tb_dm_wait_responder.sv
// Directed bench for dm_wait_responder: latency, handshake, range errors,
// reset during an access and counter saturation.
module tb_dm_wait_responder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        DM_req;
    logic        DM_enable;
    logic [15:0] DM_Address;
    logic [31:0] DM_Write_Data;
    logic [31:0] DM_Read_Data;
    logic        DM_ready;
    logic        DM_stall;
    logic        DM_err;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int checks   = 0;
    int failures = 0;

    dm_wait_responder #(
        .bit_size (32),
        .mem_size (16),
        .DEPTH    (128),
        .LATENCY  (LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .DM_req        (DM_req),
        .DM_enable     (DM_enable),
        .DM_Address    (DM_Address),
        .DM_Write_Data (DM_Write_Data),
        .DM_Read_Data  (DM_Read_Data),
        .DM_ready      (DM_ready),
        .DM_stall      (DM_stall),
        .DM_err        (DM_err),
        .rd_count      (rd_count),
        .wr_count      (wr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge of RESP
    // with the original request values back on the inputs.
    task automatic access(input logic we, input logic [15:0] a, input logic [31:0] wd);
        DM_req        = 1'b1;
        DM_enable     = we;
        DM_Address    = a;
        DM_Write_Data = wd;
        #1 chk("stall_idle_req", DM_stall, 1);
        @(posedge clk);
        @(negedge clk);
        DM_enable     = ~we;
        DM_Address    = a ^ 16'h0003;
        DM_Write_Data = ~wd;
        for (int i = 0; i < LAT; i++) begin
            chk("wait_ready", DM_ready, 0);
            chk("wait_stall", DM_stall, 1);
            @(negedge clk);
        end
        chk("resp_ready", DM_ready, 1);
        chk("resp_stall", DM_stall, 0);
        DM_enable     = we;
        DM_Address    = a;
        DM_Write_Data = wd;
    endtask

    initial begin
        rst = 1'b0; DM_req = 1'b0; DM_enable = 1'b0;
        DM_Address = '0; DM_Write_Data = '0;

        // reset, idle
        @(negedge clk); @(negedge clk);
        chk("rst_rdata", DM_Read_Data, 0);
        chk("rst_ready", DM_ready, 0);
        chk("rst_stall", DM_stall, 0);
        chk("rst_err", DM_err, 0);
        chk("rst_rdcnt", rd_count, 0);
        chk("rst_wrcnt", wr_count, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_stall", DM_stall, 0);
        chk("idle_ready", DM_ready, 0);

        // write then read addr 5
        access(1'b1, 16'd5, 32'hDEADBEEF);
        chk("wr5_mem", dut.DM_data[5], 32'hDEADBEEF);
        chk("wr5_rdata_unchanged", DM_Read_Data, 0);
        chk("wr5_wrcnt", wr_count, 1);
        DM_req = 1'b0;
        @(negedge clk);
        chk("wr5_ready_pulse", DM_ready, 0);
        chk("wr5_idle_stall", DM_stall, 0);
        access(1'b0, 16'd5, 32'h0);
        chk("rd5_data", DM_Read_Data, 32'hDEADBEEF);
        chk("rd5_rdcnt", rd_count, 1);
        chk("rd5_wrcnt", wr_count, 1);
        DM_req = 1'b0;
        @(negedge clk);
        chk("rd5_hold", DM_Read_Data, 32'hDEADBEEF);

        // preload, then back-to-back reads with req held
        access(1'b1, 16'd1, 32'h11); DM_req = 1'b0; @(negedge clk);
        access(1'b1, 16'd2, 32'h22); DM_req = 1'b0; @(negedge clk);
        access(1'b0, 16'd1, 32'h0);
        chk("b2b_rd1", DM_Read_Data, 32'h11);
        chk("b2b_rdcnt1", rd_count, 2);
        DM_Address = 16'd2;
        @(negedge clk);
        chk("b2b_gap_ready", DM_ready, 0);
        chk("b2b_gap_stall", DM_stall, 1);
        access(1'b0, 16'd2, 32'h0);
        chk("b2b_rd2", DM_Read_Data, 32'h22);
        chk("b2b_rdcnt2", rd_count, 3);
        DM_req = 1'b0;
        @(negedge clk);
        chk("b2b_err_clear", DM_err, 0);

        // out of range; addr 72 aliases 200 in the low 7 bits
        access(1'b1, 16'd72, 32'h7272); DM_req = 1'b0; @(negedge clk);
        access(1'b1, 16'd200, 32'h1234);
        chk("oor_wr_err", DM_err, 1);
        chk("oor_wrcnt", wr_count, 5);
        chk("oor_alias_mem", dut.DM_data[72], 32'h7272);
        DM_req = 1'b0;
        @(negedge clk);
        access(1'b0, 16'd200, 32'h0);
        chk("oor_rdata", DM_Read_Data, 0);
        chk("oor_rdcnt", rd_count, 4);
        DM_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("oor_err_sticky", DM_err, 1);

        // reset during WAIT drops the write
        access(1'b1, 16'd7, 32'h0707); DM_req = 1'b0; @(negedge clk);
        DM_req = 1'b1; DM_enable = 1'b1; DM_Address = 16'd7; DM_Write_Data = 32'hCAFE;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_in_wait", dut.state_q, 2'd1);
        rst = 1'b0;
        DM_req = 1'b0;
        #1;
        chk("midrst_state", dut.state_q, 2'd0);
        chk("midrst_stall", DM_stall, 0);
        chk("midrst_err", DM_err, 0);
        chk("midrst_wrcnt", wr_count, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_mem", dut.DM_data[7], 32'h0707);
        chk("midrst_stall_after", DM_stall, 0);
        chk("midrst_ready_after", DM_ready, 0);
        repeat (5) @(negedge clk);
        chk("midrst_mem_late", dut.DM_data[7], 32'h0707);
        chk("midrst_ready_late", DM_ready, 0);

        // write counter saturation
        force dut.wr_cnt_q = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.wr_cnt_q;
        #1 chk("sat_preset", wr_count, 16'hFFFE);
        @(negedge clk);
        access(1'b1, 16'd3, 32'h1); DM_req = 1'b0;
        chk("sat_first", wr_count, 16'hFFFF);
        @(negedge clk);
        access(1'b1, 16'd3, 32'h2); DM_req = 1'b0;
        chk("sat_second", wr_count, 16'hFFFF);
        @(negedge clk);
        access(1'b1, 16'd3, 32'h3); DM_req = 1'b0;
        chk("sat_third", wr_count, 16'hFFFF);
        chk("sat_mem", dut.DM_data[3], 32'h3);
        chk("sat_rdcnt", rd_count, 0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
